// File: rtl/multicycle_adder_nb_if.sv
// Request/response bus for the multicycle adder: operands in, result and flags out.
// Latency: none, this is wiring only.
// Backpressure: valid_i/ready_o on the request side, valid_o/ready_i on the result side.
interface multicycle_adder_nb_if #(
    parameter int N = 32
);
    logic         valid_i;
    logic         ready_o;
    logic         carry_i;
    logic         inv_b_i;
    logic [N-1:0] opa_i;
    logic [N-1:0] opb_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] res_o;
    logic         carry_o;
    logic         overflow_o;
    logic         zero_o;

    // Adder side: consumes requests, produces results.
    modport slave (
        input  valid_i, carry_i, inv_b_i, opa_i, opb_i, ready_i,
        output ready_o, valid_o, res_o, carry_o, overflow_o, zero_o
    );

    // Requester side: produces requests, consumes results.
    modport master (
        output valid_i, carry_i, inv_b_i, opa_i, opb_i, ready_i,
        input  ready_o, valid_o, res_o, carry_o, overflow_o, zero_o
    );
endinterface

// File: rtl/multicycle_adder_nb.sv
// N-bit add/subtract done CHUNK bits per cycle, with carry, signed overflow and zero flags.
// Latency: N/CHUNK cycles from accept to valid_o; initiation interval N/CHUNK+1.
// Backpressure: result held indefinitely while ready_i=0; ready_o only high when idle.
module multicycle_adder_nb #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_adder_nb_if.slave bus
);
    localparam int SLICES = N / CHUNK;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] opa_q, opa_d;
    logic [N-1:0] opb_q, opb_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] res_q, res_d;
    logic         carry_q, carry_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [CHUNK:0] slice_sum;
    logic [N-1:0]   acc_next;
    logic           last_slice;
    logic           a_msb, b_msb, r_msb;

    // Slice datapath: operands are shifted right each cycle so the active
    // slice is always in the low CHUNK bits; sums enter the accumulator from the top.
    always_comb begin
        slice_sum  = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        acc_next   = N'({slice_sum[CHUNK-1:0], acc_q} >> CHUNK);
        last_slice = (cnt_q == CW'(SLICES - 1));
        // On the last slice the low bits hold operand/result bit N-1.
        a_msb      = opa_q[CHUNK-1];
        b_msb      = opb_q[CHUNK-1];
        r_msb      = slice_sum[CHUNK-1];
    end

    // Next-state and datapath register updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    opa_d   = bus.opa_i;
                    opb_d   = bus.inv_b_i ? ~bus.opb_i : bus.opb_i;
                    carry_d = bus.inv_b_i ^ bus.carry_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                acc_d   = acc_next;
                carry_d = slice_sum[CHUNK];
                if (last_slice) begin
                    // Publish only the finished result; partial sums stay internal.
                    res_d   = acc_next;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = (a_msb == b_msb) && (r_msb != a_msb);
                    zero_d  = ~|acc_next;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_o    = (state_q == ST_IDLE);
    assign bus.valid_o    = (state_q == ST_DONE);
    assign bus.res_o      = res_q;
    assign bus.carry_o    = cout_q;
    assign bus.overflow_o = ovf_q;
    assign bus.zero_o     = zero_q;
endmodule

// File: doc/multicycle_adder_nb.md
Name: multicycle_adder_Nb

Overview:
Sequential, area-reduced successor to the combinational ripple-carry adder. It performs an N-bit add or subtract over N/CHUNK cycles, adding one CHUNK-bit slice per cycle and registering the carry between slices. Operands are accepted and results returned over valid/ready handshakes. Beyond carry-out, it produces signed-overflow and zero flags. It is intended for low-area ALU configurations and for multi-cycle execute stages.

Parameters:
N, 32, operand/result width; must be a multiple of CHUNK.
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= N.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous reset, active-high.
valid_i  input  1  request valid.
ready_o  output  1  block can accept a request.
carry_i  input  1  carry-in.
inv_b_i  input  1  invert operand b (subtract mode).
opa_i  input  N  operand a.
opb_i  input  N  operand b.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
res_o  output  N  sum/difference.
carry_o  output  1  carry out of bit N-1.
overflow_o  output  1  two's-complement signed overflow.
zero_o  output  1  res_o == 0.

Behaviour:
- Arithmetic: b_eff = inv_b_i ? ~opb_i : opb_i; cin_eff = inv_b_i ? ~carry_i : carry_i.
  - Result = opa_i + b_eff + cin_eff, computed modulo 2^N; carry_o is bit N of the full sum.
  - inv_b_i=1, carry_i=0 gives a-b; inv_b_i=1, carry_i=1 gives a-b-1.
- overflow_o = (a[N-1] == b_eff[N-1]) && (res[N-1] != a[N-1]).
- zero_o = ~|res_o.
- FSM states: IDLE, RUN, DONE.
  - Reset value is IDLE.
  - On reset, all outputs except ready_o are 0: res_o=0, carry_o=0, overflow_o=0, zero_o=0, valid_o=0. ready_o=1 after reset.
- IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i & ready_o, capture opa_i, b_eff and cin_eff; clear the slice counter; go to RUN.
  - Inputs are don't-care while not accepted.
- RUN:
  - ready_o=0, valid_o=0.
  - Each cycle adds slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the captured operands plus the registered carry.
  - Writes the slice result into the result register and updates the carry register; k increments.
  - After slice N/CHUNK-1 completes, latch carry_o, overflow_o and zero_o; go to DONE.
- Latency: with acceptance at edge T, valid_o rises after edge T+N/CHUNK. For CHUNK=N this is one cycle.
- DONE:
  - valid_o=1; res_o and the flags are stable, with no intermediate slice values visible.
  - Hold all outputs while ready_i=0, for unbounded backpressure.
  - On valid_o & ready_i, go to IDLE; valid_o=0 the next cycle.
  - ready_o=0 in DONE, so there is no same-cycle back-to-back accept. Minimum initiation interval is N/CHUNK+1 cycles.
- Result outputs (res_o and flags) keep their last values in IDLE and RUN; only valid_o qualifies them.
- Operand changes on inputs after acceptance have no effect.
- rst_i asserted in any state:
  - Aborts the operation and forces reset values on the next edge.
  - The in-flight result is discarded and never presented.
- rst_i has priority over valid_i and ready_i in the same cycle.
- Slice counter width is clog2(N/CHUNK) with a minimum of 1 bit; it never wraps within an operation.

Test Plan:
1. N=32, CHUNK=8: opa=5, opb=3, inv_b=0, cin=0 accepted at edge T -> valid_o after edge T+4; res=0x00000008, carry=0, ovf=0, zero=0.
2. Subtraction, inv_b=1, cin=0:
   - 3-5 -> res=0xFFFFFFFE, carry=0, ovf=0.
   - 5-3 -> res=0x00000002, carry=1.
   - 5-5 -> res=0, carry=1, zero=1.
3. Inter-slice carry and wrap: 0x000000FF+1 -> 0x00000100. 0xFFFFFFFF+1 -> res=0, carry=1, zero=1, ovf=0.
4. Signed overflow: 0x7FFFFFFF+1 -> res=0x80000000, ovf=1. 0x80000000-1 (inv_b=1) -> res=0x7FFFFFFF, ovf=1.
5. Handshake:
   - Hold ready_i=0 for 10 cycles in DONE -> valid_o and res stable, ready_o=0; valid_i pulses are ignored.
   - Then ready_i=1 -> IDLE next cycle.
   - Next request accepted, with the correct independent result.
6. Reset and parametrisation:
   - Assert rst_i during RUN slice 2 -> next cycle valid_o=0, ready_o=1, res_o=0; no stale result appears. A following request completes correctly.
   - Repeat cases 1-4 with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
